// File: rtl/smvm_pipe.sv
// smvm_pipe: sparse matrix-vector multiplier; define SMVM_SAT_OUT_EN to saturate data_o instead of wrapping
module smvm_pipe #(
  parameter int DATA_W  = 32,
  parameter int IDX_W   = 12,
  parameter int DEPTH   = 4096,
  parameter int MUL_LAT = 3,
  parameter int OUT_W   = 2*DATA_W+IDX_W
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     valid,
  input  logic                     eop,
  input  logic                     transmod,
  input  logic signed [DATA_W-1:0] data,
  input  logic [IDX_W-1:0]         row,
  input  logic [IDX_W-1:0]         column,
  input  logic                     clr_err,
  output logic                     busy,
  output logic                     valid_o,
  output logic                     eop_o,
  output logic [IDX_W-1:0]         row_o,
  output logic signed [OUT_W-1:0]  data_o,
  output logic [3:0]               err_o
);
  localparam int ACC_W = 2*DATA_W+IDX_W;
  localparam int AW = DEPTH > 1 ? $clog2(DEPTH) : 1;
  localparam logic [IDX_W:0] DEPTH_V = (IDX_W+1)'(DEPTH);

  logic signed [DATA_W-1:0]   r_ram [DEPTH];
  logic signed [DATA_W-1:0]   r_dout;
  logic [IDX_W:0]             r_wptr;
  logic                       r_vec_loaded;
  logic                       r_s1_v, r_s1_eop, r_s1_oob;
  logic signed [DATA_W-1:0]   r_s1_data;
  logic [IDX_W-1:0]           r_s1_row;
  logic [MUL_LAT-1:0]         r_m_v, r_m_eop;
  logic signed [2*DATA_W-1:0] r_m_p [MUL_LAT];
  logic [IDX_W-1:0]           r_m_row [MUL_LAT];
  logic signed [ACC_W-1:0]    r_acc;
  logic [IDX_W-1:0]           r_acc_row, r_prev_row;
  logic                       r_acc_v, r_flush, r_have_prev;

  logic                       w_vec, w_vok, w_vwr, w_mat, w_oob;
  logic [3:0]                 w_set;
  logic [AW-1:0]              w_addr;
  logic signed [2*DATA_W-1:0] w_mul, w_prod;
  logic signed [ACC_W-1:0]    w_p;
  logic                       w_pv, w_peop, w_row_chg, w_emit;
  logic [IDX_W-1:0]           w_prow;
  logic signed [OUT_W-1:0]    w_out;

  assign w_vec = valid & transmod;
  assign w_vok = w_vec & ~busy;
  assign w_vwr = w_vok & (r_wptr != DEPTH_V);
  assign w_mat = valid & ~transmod;
  assign w_oob = {1'b0, column} >= DEPTH_V;
  assign w_addr = w_oob ? '0 : AW'(column);
  assign w_set = {(w_vec & busy) | (w_mat & ~r_vec_loaded),
                  w_mat & r_have_prev & (row < r_prev_row),
                  w_mat & w_oob,
                  w_vok & (r_wptr == DEPTH_V)};
  assign w_mul = (2*DATA_W)'(r_dout) * (2*DATA_W)'(r_s1_data);
  assign w_prod = r_s1_oob ? '0 : w_mul;
  assign w_pv = r_m_v[MUL_LAT-1];
  assign w_peop = r_m_eop[MUL_LAT-1];
  assign w_prow = r_m_row[MUL_LAT-1];
  assign w_p = ACC_W'(r_m_p[MUL_LAT-1]);
  assign w_row_chg = w_prow != r_acc_row;
  assign w_emit = r_flush | (w_pv & r_acc_v & w_row_chg);
  assign busy = r_s1_v | (|r_m_v) | r_acc_v | r_flush | valid_o;

`ifdef SMVM_SAT_OUT_EN
  logic signed [ACC_W-1:0] w_hi;
  assign w_hi = r_acc >>> (OUT_W-1);
  assign w_out = (w_hi == '0 || w_hi == '1) ? OUT_W'(r_acc) :
                 r_acc[ACC_W-1] ? {1'b1, {(OUT_W-1){1'b0}}} : {1'b0, {(OUT_W-1){1'b1}}};
`else
  assign w_out = OUT_W'(r_acc);
`endif

  // vector RAM: write port for vector beats, registered read addressed by column
  always_ff @(posedge clk) begin
    if (w_vwr) r_ram[AW'(r_wptr)] <= data;
    r_dout <= r_ram[w_addr];
  end

  // write pointer and vector-loaded flag; a busy-time vector beat leaves both untouched
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wptr <= '0;
      r_vec_loaded <= 1'b0;
    end else if (w_vok) begin
      r_wptr <= eop ? '0 : r_wptr + (IDX_W+1)'(w_vwr);
      r_vec_loaded <= r_vec_loaded | eop;
    end
  end

  // sticky error flags; a new set event overrides a simultaneous clear
  always_ff @(posedge clk or posedge rst) begin
    if (rst) err_o <= '0;
    else err_o <= (clr_err ? 4'b0 : err_o) | w_set;
  end

  // pipeline valids and row-order tracking within a transfer
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s1_v <= 1'b0;
      r_m_v <= '0;
      r_prev_row <= '0;
      r_have_prev <= 1'b0;
    end else begin
      r_s1_v <= w_mat;
      for (int i = MUL_LAT-1; i > 0; i--) r_m_v[i] <= r_m_v[i-1];
      r_m_v[0] <= r_s1_v;
      if (w_mat) begin
        r_prev_row <= row;
        r_have_prev <= ~eop;
      end
    end
  end

  // beat payload through the read stage and the multiplier pipeline
  always_ff @(posedge clk) begin
    if (w_mat) begin
      r_s1_data <= data;
      r_s1_row <= row;
      r_s1_eop <= eop;
      r_s1_oob <= w_oob;
    end
    for (int i = MUL_LAT-1; i > 0; i--) begin
      r_m_p[i] <= r_m_p[i-1];
      r_m_row[i] <= r_m_row[i-1];
      r_m_eop[i] <= r_m_eop[i-1];
    end
    r_m_p[0] <= w_prod;
    r_m_row[0] <= r_s1_row;
    r_m_eop[0] <= r_s1_eop;
  end

  // row accumulator; a flush cycle empties it so a coinciding product starts fresh
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_acc <= '0;
      r_acc_row <= '0;
      r_acc_v <= 1'b0;
      r_flush <= 1'b0;
    end else if (w_pv) begin
      r_acc <= (r_flush | ~r_acc_v | w_row_chg) ? w_p : r_acc + w_p;
      r_acc_row <= w_prow;
      r_acc_v <= 1'b1;
      r_flush <= w_peop;
    end else if (r_flush) begin
      r_acc_v <= 1'b0;
      r_flush <= 1'b0;
    end
  end

  // result registers: closed row or flushed final row
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_o <= 1'b0;
      eop_o <= 1'b0;
      row_o <= '0;
      data_o <= '0;
    end else begin
      valid_o <= w_emit;
      eop_o <= r_flush;
      if (w_emit) begin
        row_o <= r_acc_row;
        data_o <= w_out;
      end
    end
  end
endmodule

// File: tb/tb_smvm_pipe.sv
// tb_smvm_pipe: two smvm_pipe instances (DEPTH 8 full width, DEPTH 4 8-bit output) on one random stream vs a row-sum model
module tb_smvm_pipe;
  logic clk = 1'b0, rst, valid, eop, transmod, clr_err;
  logic signed [7:0] data;
  logic [3:0] row, column;
  logic a_busy, a_valid, a_eop, b_busy, b_valid, b_eop;
  logic [3:0] a_row, b_row, a_err, b_err;
  logic signed [19:0] a_data;
  logic signed [7:0] b_data;

  smvm_pipe #(.DATA_W(8), .IDX_W(4), .DEPTH(8), .MUL_LAT(3), .OUT_W(20)) u_a (
    .clk(clk), .rst(rst), .valid(valid), .eop(eop), .transmod(transmod), .data(data),
    .row(row), .column(column), .clr_err(clr_err), .busy(a_busy), .valid_o(a_valid),
    .eop_o(a_eop), .row_o(a_row), .data_o(a_data), .err_o(a_err));

  smvm_pipe #(.DATA_W(8), .IDX_W(4), .DEPTH(4), .MUL_LAT(3), .OUT_W(8)) u_b (
    .clk(clk), .rst(rst), .valid(valid), .eop(eop), .transmod(transmod), .data(data),
    .row(row), .column(column), .clr_err(clr_err), .busy(b_busy), .valid_o(b_valid),
    .eop_o(b_eop), .row_o(b_row), .data_o(b_data), .err_o(b_err));

  always #5 clk = ~clk;

  typedef struct {int cyc; int r; longint v; bit e;} exp_t;
  exp_t q0[$], q1[$];
  int cyc = 0, checks = 0, failures = 0;
  int vec [2][8];
  int wp [2];
  bit vl [2];
  logic [3:0] err [2];
  longint sum [2];
  bit hv, have_prev;
  int cur_row, prev_row, last_out, act_start;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(string tag, longint obs, longint exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  function automatic int dep(int i);
    return i ? 4 : 8;
  endfunction

  function automatic bit mbusy();
    return cyc > act_start && (hv || cyc <= last_out);
  endfunction

  function automatic longint fit(int i, longint v);
    logic signed [7:0] t;
    if (i == 0) return v;
`ifdef SMVM_SAT_OUT_EN
    return v > 127 ? 127 : v < -128 ? -128 : v;
`else
    t = v[7:0];
    return longint'(t);
`endif
  endfunction

  task automatic push(int c, int r, bit e);
    exp_t x;
    for (int i = 0; i < 2; i++) begin
      x.cyc = c; x.r = r; x.v = fit(i, sum[i]); x.e = e;
      if (i == 0) q0.push_back(x); else q1.push_back(x);
    end
    last_out = c;
  endtask

  task automatic mreset();
    q0.delete(); q1.delete();
    hv = 0; have_prev = 0; cur_row = 0; prev_row = 0; last_out = -1; act_start = 0;
    for (int i = 0; i < 2; i++) begin wp[i] = 0; vl[i] = 0; err[i] = '0; sum[i] = 0; end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(int n);
    valid = 0; eop = 0;
    repeat (n) tick();
  endtask

  task automatic vbeat(int d, bit e);
    valid = 1; transmod = 1; data = 8'(d); eop = e; row = 4'(d); column = 4'(d);
    for (int i = 0; i < 2; i++) begin
      if (mbusy()) err[i][3] = 1;
      else begin
        if (wp[i] == dep(i)) err[i][0] = 1;
        else begin vec[i][wp[i]] = d; wp[i]++; end
        if (e) begin wp[i] = 0; vl[i] = 1; end
      end
    end
    tick();
    valid = 0; eop = 0;
  endtask

  task automatic mbeat(int r, int c, int d, bit e);
    longint p [2];
    valid = 1; transmod = 0; data = 8'(d); eop = e; row = 4'(r); column = 4'(c);
    for (int i = 0; i < 2; i++) begin
      if (!vl[i]) err[i][3] = 1;
      if (c >= dep(i)) err[i][1] = 1;
      if (have_prev && r < prev_row) err[i][2] = 1;
      p[i] = c >= dep(i) ? 0 : longint'(vec[i][c]) * d;
    end
    if (!(hv || cyc <= last_out)) act_start = cyc;
    if (hv && r != cur_row) push(cyc + 5, cur_row, 0);
    for (int i = 0; i < 2; i++) sum[i] = (hv && r == cur_row) ? sum[i] + p[i] : p[i];
    hv = 1; cur_row = r;
    if (e) begin push(cyc + 6, r, 1); hv = 0; end
    prev_row = r; have_prev = !e;
    tick();
    valid = 0; eop = 0;
  endtask

  task automatic vload8();
    for (int k = 0; k < 8; k++) vbeat(int'($urandom_range(0, 255)) - 128, k == 7);
  endtask

  task automatic chk_err_clear();
    chk("err_a", a_err, err[0]);
    chk("err_b", b_err, err[1]);
    clr_err = 1;
    tick();
    clr_err = 0;
    err[0] = '0; err[1] = '0;
    chk("err_a_clr", a_err, 0);
    chk("err_b_clr", b_err, 0);
  endtask

  task automatic mon(int i, bit v, bit e, int r, longint d);
    exp_t x;
    bit ev;
    ev = 0;
    if (i == 0 && q0.size() > 0 && q0[0].cyc <= cyc) begin ev = q0[0].cyc == cyc; x = q0.pop_front(); end
    if (i == 1 && q1.size() > 0 && q1[0].cyc <= cyc) begin ev = q1[0].cyc == cyc; x = q1.pop_front(); end
    chk(i ? "valid_b" : "valid_a", v, ev);
    if (ev) begin
      chk(i ? "row_b" : "row_a", r, x.r);
      chk(i ? "data_b" : "data_a", d, x.v);
      chk(i ? "eop_b" : "eop_a", e, x.e);
    end
  endtask

  always @(negedge clk) begin
    chk("busy_a", a_busy, mbusy());
    chk("busy_b", b_busy, mbusy());
    mon(0, a_valid, a_eop, a_row, longint'(a_data));
    mon(1, b_valid, b_eop, b_row, longint'(b_data));
  end

  initial begin
    rst = 1; valid = 0; eop = 0; transmod = 0; data = 0; row = 0; column = 0; clr_err = 0;
    mreset();
    repeat (3) tick();
    chk("rst_a_out", {a_valid, a_eop, a_row, a_err}, 0);
    chk("rst_a_data", a_data, 0);
    chk("rst_b_out", {b_valid, b_eop, b_row, b_err}, 0);
    chk("rst_b_data", b_data, 0);
    rst = 0;
    tick();
    // reference transfer: rows give 13 and -14
    vbeat(2, 0); vbeat(-3, 0); vbeat(5, 0); vbeat(7, 1);
    mbeat(0, 0, 4, 0); mbeat(0, 2, 1, 0); mbeat(1, 3, -2, 1);
    idle(10);
    chk_err_clear();
    // five-beat vector overflows the DEPTH 4 instance
    for (int k = 0; k < 5; k++) vbeat(10 + k, k == 4);
    mbeat(0, 0, 1, 0); mbeat(1, 1, 1, 0); mbeat(2, 2, 1, 0); mbeat(3, 3, 1, 1);
    idle(10);
    chk_err_clear();
    // sparse rows with gaps
    mbeat(0, 1, 3, 0); idle(3); mbeat(0, 2, -5, 0); idle(4); mbeat(3, 3, 2, 1);
    idle(12);
    chk_err_clear();
    // out-of-range columns and descending rows
    vload8();
    idle(2);
    chk_err_clear();
    mbeat(0, 8, 5, 0); mbeat(0, 5, 2, 0); mbeat(2, 2, 3, 0); mbeat(1, 3, 4, 1);
    idle(10);
    chk_err_clear();
    // output width limit
    vbeat(127, 1);
    mbeat(0, 0, 127, 1);
    idle(10);
    // vector beat while busy is dropped
    mbeat(0, 0, 1, 0); vbeat(9, 0); mbeat(0, 1, 1, 1);
    idle(10);
    chk_err_clear();
    // reset mid-flight, then matrix without reload
    vload8();
    mbeat(0, 1, 3, 1);
    tick();
    rst = 1;
    mreset();
    tick();
    chk("midrst_a", {a_valid, a_eop, a_row, a_err, a_busy}, 0);
    chk("midrst_b", {b_valid, b_eop, b_row, b_err, b_busy}, 0);
    rst = 0;
    idle(8);
    mbeat(0, 2, 2, 1);
    idle(10);
    chk_err_clear();
    // random transfers
    for (int t = 0; t < 30; t++) begin
      int r, n;
      if (t % 3 == 0) vload8();
      idle(int'($urandom_range(0, 2)));
      r = int'($urandom_range(0, 3));
      n = int'($urandom_range(1, 12));
      for (int k = 0; k < n; k++) begin
        mbeat(r, int'($urandom_range(0, 9)), int'($urandom_range(0, 255)) - 128, k == n - 1);
        if ($urandom_range(0, 3) == 0) idle(int'($urandom_range(1, 3)));
        if ($urandom_range(0, 9) == 0 && r > 0) r = r - int'($urandom_range(1, r));
        else if (r < 15 && $urandom_range(0, 2) == 0) r++;
      end
      idle(12);
      chk_err_clear();
    end
    idle(4);
    chk("pending", q0.size() + q1.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
